// File: rtl/validation_checker_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : validation_pkg
// Brief    : Shared types and constants for the validation checker slice.
// Revision : 1.0 - initial release
// ============================================================================
package validation_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 11;
    localparam int CNT_W_DEF  = 12;

    // Wide enough for any CNT_W up to 32; users slice it to their width.
    localparam logic [31:0] NO_MISS_IDX = '1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_PRED    = 3'd3,
        ST_DONE    = 3'd4
    } chk_state_e;

endpackage : validation_pkg
`default_nettype wire

// File: rtl/validation_checker_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : validation_checker_if
// Brief    : Validation-memory read port plus prediction valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
interface validation_checker_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic              pred_valid;
    logic [DATA_W-1:0] pred_data;
    logic              pred_ready;

    // master = checker side, slave = memory / neural-engine side
    modport master (
        output mem_addr, mem_rd_en, pred_ready,
        input  mem_data, mem_ready, pred_valid, pred_data
    );

    modport slave (
        input  mem_addr, mem_rd_en, pred_ready,
        output mem_data, mem_ready, pred_valid, pred_data
    );
endinterface : validation_checker_if
`default_nettype wire

// File: rtl/validation_checker_tol_compare.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tol_compare
// Brief    : Signed |pred - exp| <= unsigned tolerance, purely combinational.
// Revision : 1.0 - initial release
// ============================================================================
module tol_compare #(
    parameter int DATA_W = 16
) (
    input  wire logic [DATA_W-1:0] pred_data,
    input  wire logic [DATA_W-1:0] exp_data,
    input  wire logic [DATA_W-1:0] tol,
    output logic                   match
);
    logic [DATA_W:0] diff;
    logic [DATA_W:0] abs_diff;

    // One extra bit keeps -32768 vs 32767 (diff 65535) from overflowing.
    assign diff     = {pred_data[DATA_W-1], pred_data} - {exp_data[DATA_W-1], exp_data};
    assign abs_diff = diff[DATA_W] ? (~diff + (DATA_W+1)'(1)) : diff;
    assign match    = (abs_diff <= {1'b0, tol});

endmodule : tol_compare
`default_nettype wire

// File: rtl/validation_checker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : validation_checker
// Brief    : Reads expected results, compares predictions within tolerance,
//            accumulates match/mismatch statistics.
// Revision : 1.0 - initial release
// ============================================================================
module validation_checker
    import validation_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic              start,
    input  wire logic [ADDR_W-1:0] base_addr,
    input  wire logic [CNT_W-1:0]  num_samples,
    input  wire logic [DATA_W-1:0] tolerance,
    validation_checker_if.master   bus,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       match_count,
    output logic [CNT_W-1:0]       mismatch_count,
    output logic [CNT_W-1:0]       first_miss_idx,
    output logic                   first_miss_valid
);
    localparam logic [CNT_W-1:0] C_NO_MISS = NO_MISS_IDX[CNT_W-1:0];
    localparam logic [CNT_W-1:0] C_SAT     = '1;

    chk_state_e        state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  num_q, idx_q, match_q, miss_q, fmi_q;
    logic [DATA_W-1:0] tol_q, exp_q;
    logic              fmv_q, busy_q, done_q;

    logic [CNT_W-1:0]  idx_inc;
    logic              accept, is_match, last_sample;

    assign idx_inc     = idx_q + CNT_W'(1);
    assign last_sample = (idx_inc == num_q);
    assign accept      = (state_q == ST_PRED) && bus.pred_valid;

    tol_compare #(.DATA_W(DATA_W)) u_tol_compare (
        .pred_data (bus.pred_data),
        .exp_data  (exp_q),
        .tol       (tol_q),
        .match     (is_match)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = (num_samples == '0) ? ST_DONE : ST_RD_REQ;
            ST_RD_REQ:  state_d = ST_RD_WAIT;
            ST_RD_WAIT: if (bus.mem_ready) state_d = ST_PRED;
            ST_PRED:    if (bus.pred_valid) state_d = last_sample ? ST_DONE : ST_RD_REQ;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Address is forced to zero outside a request so it reads as idle.
    always_comb begin
        bus.mem_rd_en  = (state_q == ST_RD_REQ);
        bus.mem_addr   = bus.mem_rd_en ? (base_q + ADDR_W'(idx_q)) : '0;
        bus.pred_ready = (state_q == ST_PRED);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q  <= '0;
            num_q   <= '0;
            tol_q   <= '0;
            idx_q   <= '0;
            exp_q   <= '0;
            match_q <= '0;
            miss_q  <= '0;
            fmi_q   <= C_NO_MISS;
            fmv_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state_q == ST_DONE);
            if (state_q == ST_DONE) busy_q <= 1'b0;

            if ((state_q == ST_IDLE) && start) begin
                base_q  <= base_addr;
                num_q   <= num_samples;
                tol_q   <= tolerance;
                idx_q   <= '0;
                match_q <= '0;
                miss_q  <= '0;
                fmi_q   <= C_NO_MISS;
                fmv_q   <= 1'b0;
                busy_q  <= 1'b1;
            end

            if ((state_q == ST_RD_WAIT) && bus.mem_ready) exp_q <= bus.mem_data;

            if (accept) begin
                idx_q <= idx_inc;
                if (is_match) begin
                    if (match_q != C_SAT) match_q <= match_q + CNT_W'(1);
                end else begin
                    if (miss_q != C_SAT) miss_q <= miss_q + CNT_W'(1);
                    if (!fmv_q) begin
                        fmi_q <= idx_q;
                        fmv_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign match_count      = match_q;
    assign mismatch_count   = miss_q;
    assign first_miss_idx   = fmi_q;
    assign first_miss_valid = fmv_q;

endmodule : validation_checker
`default_nettype wire

// File: tb/tb_validation_checker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_validation_checker
// Brief    : Self-checking bench: directed plus randomized runs against a
//            behavioural model of the tolerance scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_validation_checker;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [10:0] base_addr;
    logic [11:0] num_samples;
    logic [15:0] tolerance;
    logic        busy, done, first_miss_valid;
    logic [11:0] match_count, mismatch_count, first_miss_idx;

    logic [15:0] mem   [0:2047];
    logic [15:0] preds [0:2047];
    bit          spur_en;
    int          n_cmp;
    int          n_fail;

    validation_checker_if #(.DATA_W(16), .ADDR_W(11)) bus ();

    validation_checker #(.DATA_W(16), .ADDR_W(11), .CNT_W(12)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .base_addr        (base_addr),
        .num_samples      (num_samples),
        .tolerance        (tolerance),
        .bus              (bus),
        .busy             (busy),
        .done             (done),
        .match_count      (match_count),
        .mismatch_count   (mismatch_count),
        .first_miss_idx   (first_miss_idx),
        .first_miss_valid (first_miss_valid)
    );

    always #5 clk = ~clk;

    // Memory model: answers one cycle after a request; optionally injects
    // stray ready pulses with junk data when no request is pending.
    always @(posedge clk) begin
        if (bus.mem_rd_en) begin
            bus.mem_ready <= 1'b1;
            bus.mem_data  <= mem[bus.mem_addr];
        end else if (spur_en && ($urandom_range(7) == 0)) begin
            bus.mem_ready <= 1'b1;
            bus.mem_data  <= 16'($urandom);
        end else begin
            bus.mem_ready <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic run_case(input string tag, input int base, input int n, input int tol,
                            input int gap_pct, input bit stray_start);
        int em, emm, efirst, e, p, d, k, done_cyc, budget;
        int eaddr[$];
        int gaddr[$];
        em = 0; emm = 0; efirst = -1; done_cyc = -1; k = 0;
        budget = 30 * n + 20;
        for (int i = 0; i < n; i++) begin
            eaddr.push_back((base + i) % 2048);
            e = int'($signed(mem[(base + i) % 2048]));
            p = int'($signed(preds[i]));
            d = (p > e) ? (p - e) : (e - p);
            if (d <= tol) em++;
            else begin
                emm++;
                if (efirst < 0) efirst = i;
            end
        end

        @(negedge clk);
        start = 1'b1; base_addr = 11'(base); num_samples = 12'(n); tolerance = 16'(tol);
        bus.pred_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy_after_start"}, busy, 1);
        for (int cyc = 1; cyc <= budget; cyc++) begin
            if (bus.mem_rd_en) gaddr.push_back(int'(bus.mem_addr));
            if (done) begin
                done_cyc = cyc;
                start = 1'b0;
                bus.pred_valid = 1'b0;
                break;
            end
            start = stray_start && ($urandom_range(7) == 0);
            if (start) begin
                base_addr   = 11'($urandom);
                num_samples = 12'($urandom_range(1, 9));
                tolerance   = 16'($urandom);
            end
            bus.pred_valid = (k < n) && (int'($urandom_range(99)) >= gap_pct);
            bus.pred_data  = (k < n) ? preds[k] : 16'($urandom);
            #1;
            if (bus.pred_valid && bus.pred_ready) k++;
            @(negedge clk);
        end
        start = 1'b0;
        bus.pred_valid = 1'b0;

        check({tag, " done_seen"}, (done_cyc > 0), 1);
        if (n == 0) check({tag, " done_latency"}, done_cyc, 2);
        check({tag, " busy_at_done"}, busy, 0);
        check({tag, " accepted"}, k, n);
        check({tag, " match_count"}, match_count, em);
        check({tag, " mismatch_count"}, mismatch_count, emm);
        check({tag, " first_miss_valid"}, first_miss_valid, (efirst >= 0));
        check({tag, " first_miss_idx"}, first_miss_idx, (efirst >= 0) ? efirst : 12'hFFF);
        check({tag, " rd_count"}, gaddr.size(), n);
        for (int i = 0; i < n && i < gaddr.size(); i++)
            check({tag, " mem_addr"}, gaddr[i], eaddr[i]);
        @(negedge clk);
        check({tag, " done_one_pulse"}, done, 0);
        check({tag, " counts_hold"}, match_count, em);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " match_count"}, match_count, 0);
        check({tag, " mismatch_count"}, mismatch_count, 0);
        check({tag, " first_miss_idx"}, first_miss_idx, 12'hFFF);
        check({tag, " first_miss_valid"}, first_miss_valid, 0);
        check({tag, " mem_rd_en"}, bus.mem_rd_en, 0);
        check({tag, " mem_addr"}, bus.mem_addr, 0);
        check({tag, " pred_ready"}, bus.pred_ready, 0);
    endtask

    initial begin
        int n, base, dones;
        n_cmp = 0; n_fail = 0; spur_en = 1'b0;
        reset_n = 1'b0; start = 1'b0; base_addr = '0; num_samples = '0; tolerance = '0;
        bus.pred_valid = 1'b0; bus.pred_data = '0;
        bus.mem_ready = 1'b0; bus.mem_data = '0;
        for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        reset_n = 1'b1;

        mem[0] = 16'd10; mem[1] = 16'hFFFB; mem[2] = 16'd100; mem[3] = 16'd0;
        preds[0] = 16'd10; preds[1] = 16'hFFFB; preds[2] = 16'd100; preds[3] = 16'd0;
        run_case("exact_tol0", 0, 4, 0, 0, 1'b0);

        preds[0] = 16'd12; preds[1] = 16'hFFF8; preds[2] = 16'd100; preds[3] = 16'd1;
        run_case("tol2", 0, 4, 2, 0, 1'b0);
        check("tol2 plan_first_miss", first_miss_idx, 1);

        mem[2046] = 16'd1; mem[2047] = 16'd2; mem[0] = 16'd3; mem[1] = 16'd4;
        preds[0] = 16'd1; preds[1] = 16'd2; preds[2] = 16'd3; preds[3] = 16'd4;
        run_case("wrap", 2046, 4, 0, 30, 1'b0);

        run_case("n_zero", 0, 0, 0, 0, 1'b0);

        mem[5] = 16'h8000; preds[0] = 16'h7FFF;
        run_case("extreme_ffff", 5, 1, 16'hFFFF, 0, 1'b0);
        check("extreme_ffff plan_match", match_count, 1);
        run_case("extreme_fffe", 5, 1, 16'hFFFE, 0, 1'b0);
        check("extreme_fffe plan_miss", mismatch_count, 1);

        // Abandon a run by reset while stalled in the prediction phase.
        for (int i = 0; i < 8; i++) preds[i] = mem[100 + i];
        @(negedge clk);
        start = 1'b1; base_addr = 11'd100; num_samples = 12'd8; tolerance = 16'd0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !bus.pred_ready; i++) @(negedge clk);
        check("rst_mid pred_ready_reached", bus.pred_ready, 1);
        repeat (20) @(negedge clk);
        check("rst_mid stalled", bus.pred_ready, 1);
        reset_n = 1'b0;
        #1;
        check_reset_values("rst_mid");
        @(negedge clk);
        reset_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("rst_mid no_done", dones, 0);
        run_case("after_reset", 100, 8, 0, 20, 1'b0);

        spur_en = 1'b1;
        for (int t = 0; t < 8; t++) begin
            n = $urandom_range(1, 40);
            base = $urandom_range(0, 2047);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(9) == 0) preds[i] = 16'($urandom);
                else preds[i] = mem[(base + i) % 2048] + 16'($urandom_range(0, 20)) - 16'd10;
            end
            run_case($sformatf("rand%0d", t), base, n, $urandom_range(0, 8),
                     $urandom_range(0, 60), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_validation_checker
`default_nettype wire
